fig_04b_block_077_z_writeback: RTL and testbench

Writeback unit and storage for the sixteen 16-bit general registers R0–R15. It accepts ALU results from the Z bus, assembles 16-bit loads that arrive as byte pairs from the 8-bit memory bus, and auto-increments R15 (the program counter). It drives r00–r15 continuously to the Y/X select blocks. It is the write end of the register-file path, whose read end samples on the falling edge.

---
 rtl/fig_04b_block_077_z_writeback.sv | 168 ++++++++++++++++
 tb/tb_fig_04b_block_077_z_writeback.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fig_04b_block_077_z_writeback.sv
// Writeback unit and storage for general registers R0-R15.
// Takes Z-bus ALU results (word or byte-lane writes), assembles 16-bit
// loads from byte pairs on the 8-bit memory bus, and auto-increments R15.
//
// Load sequencer states:
//   state      | meaning
//   ST_IDLE    | no load in progress; ld_start accepted
//   ST_WAIT_LO | destination latched, waiting for the low byte
//   ST_WAIT_HI | low byte held, waiting for the high byte (completion)
module fig_04b_block_077_z_writeback (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        z_we,
    input  logic [3:0]  zsel,
    input  logic [15:0] zbus,
    input  logic [1:0]  zmode,
    input  logic        pc_inc,
    input  logic        ld_start,
    input  logic [3:0]  ld_dst,
    input  logic        ld_byte_valid,
    input  logic [7:0]  ld_byte,
    output logic        ld_busy,
    output logic        r15_written,
    output logic [15:0] r00,
    output logic [15:0] r01,
    output logic [15:0] r02,
    output logic [15:0] r03,
    output logic [15:0] r04,
    output logic [15:0] r05,
    output logic [15:0] r06,
    output logic [15:0] r07,
    output logic [15:0] r08,
    output logic [15:0] r09,
    output logic [15:0] r10,
    output logic [15:0] r11,
    output logic [15:0] r12,
    output logic [15:0] r13,
    output logic [15:0] r14,
    output logic [15:0] r15
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_LO = 2'd1,
        ST_WAIT_HI = 2'd2
    } ld_state_t;

    ld_state_t   state_q, state_d;
    logic [3:0]  dst_q, dst_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] regs_q [16];
    logic [15:0] regs_d [16];
    logic        r15_written_q, r15_written_d;
    logic        ld_commit;

    // Byte-lane merge of Z-bus data into the current (pre-increment) value.
    function automatic logic [15:0] z_merge(input logic [15:0] cur,
                                            input logic [15:0] data,
                                            input logic [1:0]  mode);
        logic [15:0] res;
        case (mode)
            2'b01:   res = {cur[15:8], data[7:0]};
            2'b10:   res = {data[15:8], cur[7:0]};
            default: res = data;
        endcase
        return res;
    endfunction

    // Sequencer state, latched destination and low byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dst_q   <= 4'd0;
            lo_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            dst_q   <= dst_d;
            lo_q    <= lo_d;
        end
    end

    // Sequencer next state; ld_start outside IDLE and bytes in IDLE are ignored.
    always_comb begin
        state_d = state_q;
        dst_d   = dst_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (ld_start) begin
                    state_d = ST_WAIT_LO;
                    dst_d   = ld_dst;
                end
            end
            ST_WAIT_LO: begin
                if (ld_byte_valid) begin
                    state_d = ST_WAIT_HI;
                    lo_d    = ld_byte;
                end
            end
            ST_WAIT_HI: begin
                if (ld_byte_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer outputs decoded from the state register.
    always_comb begin
        ld_busy   = (state_q != ST_IDLE);
        ld_commit = (state_q == ST_WAIT_HI) && ld_byte_valid;
    end

    // Register next values; priority Z write > load completion > pc_inc.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            regs_d[i] = regs_q[i];
            if (i == 15 && pc_inc) begin
                regs_d[i] = regs_q[i] + 16'd1;
            end
            if (ld_commit && dst_q == 4'(i)) begin
                regs_d[i] = {ld_byte, lo_q};
            end
            if (z_we && zsel == 4'(i)) begin
                regs_d[i] = z_merge(regs_q[i], zbus, zmode);
            end
        end
        r15_written_d = (z_we && zsel == 4'd15) || (ld_commit && dst_q == 4'd15);
    end

    // Register storage and the prefetch-flush pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= 16'd0;
            end
            r15_written_q <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= regs_d[i];
            end
            r15_written_q <= r15_written_d;
        end
    end

    // Register contents go straight from the flops to the select blocks.
    always_comb begin
        r15_written = r15_written_q;
        r00 = regs_q[0];
        r01 = regs_q[1];
        r02 = regs_q[2];
        r03 = regs_q[3];
        r04 = regs_q[4];
        r05 = regs_q[5];
        r06 = regs_q[6];
        r07 = regs_q[7];
        r08 = regs_q[8];
        r09 = regs_q[9];
        r10 = regs_q[10];
        r11 = regs_q[11];
        r12 = regs_q[12];
        r13 = regs_q[13];
        r14 = regs_q[14];
        r15 = regs_q[15];
    end

endmodule

// File: tb/tb_fig_04b_block_077_z_writeback.sv
// Bench for the writeback unit: directed vector table, hand-written load
// sequences, then randomized traffic against a reference model.
module tb_fig_04b_block_077_z_writeback;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        z_we = 1'b0;
    logic [3:0]  zsel = 4'd0;
    logic [15:0] zbus = 16'd0;
    logic [1:0]  zmode = 2'd0;
    logic        pc_inc = 1'b0;
    logic        ld_start = 1'b0;
    logic [3:0]  ld_dst = 4'd0;
    logic        ld_byte_valid = 1'b0;
    logic [7:0]  ld_byte = 8'd0;
    logic        ld_busy;
    logic        r15_written;
    wire  [15:0] rv [16];

    int total = 0;
    int bad = 0;

    // reference model: register image plus a description of the load in flight
    logic [15:0] m_r [16];
    logic        m_active, m_have_lo, m_r15w;
    logic [3:0]  m_dst;
    logic [7:0]  m_lo;

    fig_04b_block_077_z_writeback dut (
        .clk(clk), .rst_n(rst_n), .z_we(z_we), .zsel(zsel), .zbus(zbus),
        .zmode(zmode), .pc_inc(pc_inc), .ld_start(ld_start), .ld_dst(ld_dst),
        .ld_byte_valid(ld_byte_valid), .ld_byte(ld_byte), .ld_busy(ld_busy),
        .r15_written(r15_written),
        .r00(rv[0]), .r01(rv[1]), .r02(rv[2]), .r03(rv[3]),
        .r04(rv[4]), .r05(rv[5]), .r06(rv[6]), .r07(rv[7]),
        .r08(rv[8]), .r09(rv[9]), .r10(rv[10]), .r11(rv[11]),
        .r12(rv[12]), .r13(rv[13]), .r14(rv[14]), .r15(rv[15])
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        z_we = 0; zsel = 0; zbus = 0; zmode = 0; pc_inc = 0;
        ld_start = 0; ld_dst = 0; ld_byte_valid = 0; ld_byte = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_r[i] = 16'd0;
        m_active = 0; m_have_lo = 0; m_r15w = 0; m_dst = 0; m_lo = 0;
    endtask

    // Apply the currently driven inputs for one rising edge; model follows along.
    task automatic step();
        logic [15:0] nr [16];
        logic [15:0] base;
        logic        done;
        for (int i = 0; i < 16; i++) nr[i] = m_r[i];
        done = m_active && m_have_lo && ld_byte_valid;
        if (pc_inc) nr[15] = m_r[15] + 16'd1;
        if (done) nr[m_dst] = {ld_byte, m_lo};
        if (z_we) begin
            base = m_r[zsel];
            if (zmode == 2'b01)      nr[zsel] = {base[15:8], zbus[7:0]};
            else if (zmode == 2'b10) nr[zsel] = {zbus[15:8], base[7:0]};
            else                     nr[zsel] = zbus;
        end
        m_r15w = (z_we && zsel == 4'd15) || (done && m_dst == 4'd15);
        if (!m_active) begin
            if (ld_start) begin m_active = 1; m_have_lo = 0; m_dst = ld_dst; end
        end else if (!m_have_lo) begin
            if (ld_byte_valid) begin m_lo = ld_byte; m_have_lo = 1; end
        end else if (ld_byte_valid) begin
            m_active = 0; m_have_lo = 0;
        end
        for (int i = 0; i < 16; i++) m_r[i] = nr[i];
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 16; i++) check($sformatf("%s r%0d", tag, i), rv[i], 16'd0);
        check({tag, " ld_busy"}, 16'(ld_busy), 16'd0);
        check({tag, " r15_written"}, 16'(r15_written), 16'd0);
    endtask

    task automatic do_reset();
        clear_inputs();
        #2 rst_n = 0;
        #1 model_reset();
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    // offer one memory byte after 'gap' idle cycles
    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int g = 0; g < gap; g++) begin
            step();
            check("gap ld_busy", 16'(ld_busy), 16'd1);
        end
        ld_byte_valid = 1; ld_byte = b;
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [1:0]  mode;
        logic [15:0] data;
        logic        pc;
        logic [3:0]  chk;
        logic [15:0] exp_val;
        logic        exp_r15w;
    } vec_t;

    vec_t vt [13];

    initial begin
        vt[0]  = '{1, 4'd3,  2'b00, 16'h1234, 0, 4'd3,  16'h1234, 0};
        vt[1]  = '{1, 4'd15, 2'b00, 16'hBEEF, 0, 4'd15, 16'hBEEF, 1};
        vt[2]  = '{0, 4'd15, 2'b00, 16'h0000, 0, 4'd15, 16'hBEEF, 0};
        vt[3]  = '{1, 4'd7,  2'b11, 16'hAABB, 0, 4'd7,  16'hAABB, 0};
        vt[4]  = '{1, 4'd7,  2'b01, 16'h00CC, 0, 4'd7,  16'hAACC, 0};
        vt[5]  = '{1, 4'd7,  2'b10, 16'hDD00, 0, 4'd7,  16'hDDCC, 0};
        vt[6]  = '{1, 4'd15, 2'b00, 16'hFFFF, 0, 4'd15, 16'hFFFF, 1};
        vt[7]  = '{0, 4'd0,  2'b00, 16'h0000, 1, 4'd15, 16'h0000, 0};
        vt[8]  = '{1, 4'd15, 2'b00, 16'h8000, 1, 4'd15, 16'h8000, 1};
        vt[9]  = '{0, 4'd0,  2'b00, 16'h0000, 1, 4'd15, 16'h8001, 0};
        vt[10] = '{1, 4'd15, 2'b01, 16'h00AA, 1, 4'd15, 16'h80AA, 1};
        vt[11] = '{1, 4'd15, 2'b10, 16'h12FF, 1, 4'd15, 16'h12AA, 1};
        vt[12] = '{1, 4'd0,  2'b11, 16'hFFFF, 0, 4'd3,  16'h1234, 0};

        model_reset();
        do_reset();

        for (int k = 0; k < 13; k++) begin
            clear_inputs();
            z_we = vt[k].we; zsel = vt[k].sel; zmode = vt[k].mode;
            zbus = vt[k].data; pc_inc = vt[k].pc;
            step();
            check($sformatf("vec%0d r%0d", k, vt[k].chk), rv[vt[k].chk], vt[k].exp_val);
            check($sformatf("vec%0d r15_written", k), 16'(r15_written), 16'(vt[k].exp_r15w));
        end
        clear_inputs();
        check("vec r00 full word", rv[0], 16'hFFFF);

        // load with gaps; a byte in the ld_start cycle must be ignored
        ld_start = 1; ld_dst = 4'd5; ld_byte_valid = 1; ld_byte = 8'h99;
        step();
        clear_inputs();
        check("load start busy", 16'(ld_busy), 16'd1);
        send_byte(8'h34, 1);
        step();
        clear_inputs();
        check("load lo busy", 16'(ld_busy), 16'd1);
        send_byte(8'h12, 3);
        step();
        clear_inputs();
        check("load r05", rv[5], 16'h1234);
        check("load done busy", 16'(ld_busy), 16'd0);

        // ld_start in the completion cycle is not accepted; ld_start mid-load ignored
        ld_start = 1; ld_dst = 4'd8;
        step();
        clear_inputs();
        ld_byte_valid = 1; ld_byte = 8'h22; ld_start = 1; ld_dst = 4'd9;
        step();
        clear_inputs();
        ld_byte_valid = 1; ld_byte = 8'h11; ld_start = 1; ld_dst = 4'd6;
        step();
        clear_inputs();
        check("redirect r08", rv[8], 16'h1122);
        check("redirect r09", rv[9], 16'h0000);
        check("completion start busy", 16'(ld_busy), 16'd0);

        // load to R15 beats pc_inc and flags a flush
        ld_start = 1; ld_dst = 4'd15;
        step();
        clear_inputs();
        ld_byte_valid = 1; ld_byte = 8'h78;
        step();
        clear_inputs();
        ld_byte_valid = 1; ld_byte = 8'h56; pc_inc = 1;
        step();
        clear_inputs();
        check("load r15", rv[15], 16'h5678);
        check("load r15_written", 16'(r15_written), 16'd1);
        step();
        check("load r15_written drop", 16'(r15_written), 16'd0);

        // same-register collision: Z wins, sequencer still idles
        ld_start = 1; ld_dst = 4'd2;
        step();
        clear_inputs();
        ld_byte_valid = 1; ld_byte = 8'h55;
        step();
        clear_inputs();
        ld_byte_valid = 1; ld_byte = 8'h55; z_we = 1; zsel = 4'd2; zbus = 16'h0A0A;
        step();
        clear_inputs();
        check("collide r02", rv[2], 16'h0A0A);
        check("collide busy", 16'(ld_busy), 16'd0);

        // different registers: both commit
        ld_start = 1; ld_dst = 4'd2;
        step();
        clear_inputs();
        ld_byte_valid = 1; ld_byte = 8'h55;
        step();
        clear_inputs();
        ld_byte_valid = 1; ld_byte = 8'h55; z_we = 1; zsel = 4'd4; zbus = 16'h0A0A;
        step();
        clear_inputs();
        check("split r02", rv[2], 16'h5555);
        check("split r04", rv[4], 16'h0A0A);

        // reset in WAIT_HI aborts the load
        ld_start = 1; ld_dst = 4'd1;
        step();
        clear_inputs();
        ld_byte_valid = 1; ld_byte = 8'hC3;
        step();
        clear_inputs();
        check("pre-reset busy", 16'(ld_busy), 16'd1);
        do_reset();
        ld_byte_valid = 1; ld_byte = 8'h3C;
        step();
        clear_inputs();
        check("stray byte r01", rv[1], 16'h0000);
        check("stray byte busy", 16'(ld_busy), 16'd0);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            z_we = ($urandom_range(0, 2) == 0);
            zsel = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            zbus = 16'($urandom);
            zmode = 2'($urandom_range(0, 3));
            pc_inc = ($urandom_range(0, 3) == 0);
            ld_start = ($urandom_range(0, 4) == 0);
            ld_dst = 4'($urandom_range(0, 15));
            ld_byte_valid = ($urandom_range(0, 2) == 0);
            ld_byte = 8'($urandom);
            step();
            for (int i = 0; i < 16; i++) check($sformatf("rand%0d r%0d", n, i), rv[i], m_r[i]);
            check($sformatf("rand%0d ld_busy", n), 16'(ld_busy), 16'(m_active));
            check($sformatf("rand%0d r15_written", n), 16'(r15_written), 16'(m_r15w));
        end
        clear_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
